// File: rtl/mcu_stream_sched_if.sv
// Pixel stream bundle between the MCU stream scheduler and the downstream
// pixel consumer. The master drives the beat and its position tags; the
// slave returns ready.
interface mcu_stream_sched_if #(
  parameter int PIX_W = 32,
  parameter int SEL_W = 11
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [2:0]       pix_row;
  logic [2:0]       pix_col;
  logic [SEL_W-1:0] mcu_idx;
  logic             last_pix;

  modport master (
    output pix_data, pix_valid, pix_row, pix_col, mcu_idx, last_pix,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_row, pix_col, mcu_idx, last_pix,
    output pix_ready
  );
endinterface

// File: rtl/mcu_stream_sched.sv
// MCU stream scheduler: walks the MCU multiplexer select over a requested
// number of MCUs, snapshots each selected 8x8 block into a local buffer and
// streams its pixels in raster order over a valid/ready interface.
module mcu_stream_sched #(
  parameter int NUM_MCU = 28,
  parameter int SEL_W   = 11,
  parameter int PIX_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [SEL_W-1:0]             i_mcu_count,
  output logic [SEL_W-1:0]             o_sel,
  input  logic [7:0][7:0][PIX_W-1:0]   i_mcu_in,
  output logic                         o_busy,
  output logic                         o_done,
  mcu_stream_sched_if.master           pix
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_FIN
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [SEL_W-1:0]           r_cnt;
  logic [SEL_W-1:0]           r_sel;
  logic [SEL_W-1:0]           r_mcu_idx;
  logic [2:0]                 r_row;
  logic [2:0]                 r_col;
  logic [PIX_W-1:0]           r_pix_data;
  logic [7:0][7:0][PIX_W-1:0] r_buf;

  logic [SEL_W-1:0]           w_cnt_clamped;
  logic [SEL_W:0]             w_idx_inc;
  logic [2:0]                 w_row_next;
  logic [2:0]                 w_col_next;
  logic                       w_mcu_end;
  logic                       w_more;
  logic                       w_last;
  logic                       w_valid;
  logic                       w_busy;
  logic                       w_done;
  logic                       w_xfer;

  // A request larger than the multiplexer width is clamped so sel never
  // addresses a nonexistent MCU input.
  assign w_cnt_clamped = (i_mcu_count > SEL_W'(NUM_MCU)) ? SEL_W'(NUM_MCU) : i_mcu_count;

  // One extra bit keeps idx+1 from wrapping when compared with the count.
  assign w_idx_inc  = {1'b0, r_mcu_idx} + (SEL_W + 1)'(1);
  assign w_more     = (w_idx_inc < {1'b0, r_cnt});

  // Raster order: column advances every beat, row advances on column wrap.
  assign w_col_next = r_col + 3'd1;
  assign w_row_next = (r_col == 3'd7) ? (r_row + 3'd1) : r_row;
  assign w_mcu_end  = (r_row == 3'd7) && (r_col == 3'd7);

  assign w_last     = (r_state == ST_STREAM) && w_mcu_end && (w_idx_inc == {1'b0, r_cnt});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-state status outputs.
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (w_cnt_clamped == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_busy       = 1'b1;
        w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_xfer  = pix.pix_ready;
        if (w_xfer && w_mcu_end) begin
          w_state_next = w_more ? ST_LOAD : ST_FIN;
        end
      end
      ST_FIN: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencing datapath: count latch, select/index stepping, raster position
  // and the registered pixel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sel      <= '0;
      r_mcu_idx  <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_pix_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt <= w_cnt_clamped;
            if (w_cnt_clamped != '0) begin
              r_sel     <= '0;
              r_mcu_idx <= '0;
            end
          end
        end
        ST_LOAD: begin
          // The buffer is being written this same edge, so the first pixel
          // is taken straight from the multiplexer.
          r_row      <= 3'd0;
          r_col      <= 3'd0;
          r_pix_data <= i_mcu_in[0][0];
        end
        ST_STREAM: begin
          if (w_xfer) begin
            r_row      <= w_row_next;
            r_col      <= w_col_next;
            r_pix_data <= r_buf[w_row_next][w_col_next];
            if (w_mcu_end && w_more) begin
              r_sel     <= r_sel + SEL_W'(1);
              r_mcu_idx <= r_mcu_idx + SEL_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Block capture: the whole selected MCU is snapshotted at the end of LOAD.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_buf <= i_mcu_in;
    end
  end

  assign o_sel         = r_sel;
  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign pix.pix_data  = r_pix_data;
  assign pix.pix_valid = w_valid;
  assign pix.pix_row   = r_row;
  assign pix.pix_col   = r_col;
  assign pix.mcu_idx   = r_mcu_idx;
  assign pix.last_pix  = w_last;

endmodule
